// File: rtl/age_issue_queue.sv
// Unified out-of-order issue queue: multi-lane enqueue, tag wakeup, one pick per FU class, redirect squash.
// Define IQ_AGE_SELECT_EN to pick the oldest ready entry per class; otherwise the lowest-index ready entry wins.
module age_issue_queue #(
    parameter int DEPTH = 16,
    parameter int ENW   = 2,
    parameter int NFU   = 4,
    parameter int WKW   = 3,
    parameter int TAGW  = 7,
    parameter int OPW   = 6,
    parameter int PW    = 128
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ENW-1:0]            enq_valid,
    output logic [ENW-1:0]            enq_ready,
    input  logic [ENW*OPW-1:0]        enq_opid,
    input  logic [ENW*NFU-1:0]        enq_fu,
    input  logic [ENW*2*TAGW-1:0]     enq_src,
    input  logic [ENW*2-1:0]          enq_busy,
    input  logic [ENW*PW-1:0]         enq_payload,
    input  logic [WKW-1:0]            wk_valid,
    input  logic [WKW*TAGW-1:0]       wk_tag,
    input  logic [NFU-1:0]            fu_ready,
    input  logic                      flush_valid,
    input  logic [OPW-1:0]            flush_opid,
    input  logic [OPW-1:0]            flush_head,
    output logic [NFU-1:0]            iss_valid,
    output logic [NFU*OPW-1:0]        iss_opid,
    output logic [NFU*PW-1:0]         iss_payload,
    output logic [$clog2(DEPTH):0]    occ_cnt
);
    localparam int IDXW = $clog2(DEPTH);
    localparam int CNTW = IDXW + 1;

    logic [DEPTH-1:0]                 valid_q, valid_d;
    logic [DEPTH-1:0][1:0]            busy_q, busy_now;
    logic [DEPTH-1:0][OPW-1:0]        opid_q, opid_rel;
    logic [DEPTH-1:0][NFU-1:0]        fu_q;
    logic [DEPTH-1:0][1:0][TAGW-1:0]  src_q;
    logic [DEPTH-1:0][PW-1:0]         payload_q;
    logic [CNTW-1:0]                  occ_q, occ_d;
    logic [NFU-1:0]                   iss_valid_q;
    logic [NFU*OPW-1:0]               iss_opid_q;
    logic [NFU*PW-1:0]                iss_payload_q;
`ifdef IQ_AGE_SELECT_EN
    // age_q[k][e] set means entry k is older than entry e.
    logic [DEPTH-1:0][DEPTH-1:0]      age_q, age_d;
`endif

    logic [OPW-1:0]                   flush_rel;
    logic [DEPTH-1:0]                 squash, rdy, issued, taken;
    logic [ENW-1:0]                   alloc_ok;
    logic [ENW-1:0][IDXW-1:0]         alloc_idx;
    logic [NFU-1:0]                   sel_ok;
    logic [NFU-1:0][IDXW-1:0]         sel_idx;

    function automatic logic wk_hit(input logic [TAGW-1:0] t, input logic [WKW-1:0] v,
                                    input logic [WKW*TAGW-1:0] tags);
        logic h;
        h = 1'b0;
        for (int w = 0; w < WKW; w++)
            if (v[w] && tags[w*TAGW +: TAGW] == t) h = 1'b1;
        return h;
    endfunction

    always_comb begin
        logic [DEPTH-1:0] cand;
        logic             blocked;
        flush_rel = flush_opid - flush_head;
        for (int e = 0; e < DEPTH; e++) begin
            for (int s = 0; s < 2; s++)
                busy_now[e][s] = busy_q[e][s] & ~wk_hit(src_q[e][s], wk_valid, wk_tag);
            // Distances from the ROB head make the age compare immune to opid wrap.
            opid_rel[e] = opid_q[e] - flush_head;
            squash[e]   = flush_valid & (opid_rel[e] > flush_rel);
            rdy[e]      = valid_q[e] & ~busy_now[e][0] & ~busy_now[e][1] & ~squash[e];
        end

        for (int i = 0; i < ENW; i++)
            enq_ready[i] = ((DEPTH - int'(occ_q)) > i) && !flush_valid;

        taken = '0;
        for (int i = 0; i < ENW; i++) begin
            alloc_ok[i]  = 1'b0;
            alloc_idx[i] = '0;
            if (enq_valid[i] && enq_ready[i])
                for (int e = 0; e < DEPTH; e++)
                    if (!valid_q[e] && !taken[e] && !alloc_ok[i]) begin
                        alloc_ok[i]  = 1'b1;
                        alloc_idx[i] = IDXW'(e);
                    end
            if (alloc_ok[i]) taken[alloc_idx[i]] = 1'b1;
        end

        issued = '0;
        cand   = '0;
        for (int j = 0; j < NFU; j++) begin
            sel_ok[j]  = 1'b0;
            sel_idx[j] = '0;
            for (int e = 0; e < DEPTH; e++) cand[e] = rdy[e] & fu_q[e][j];
            for (int e = 0; e < DEPTH; e++) begin
                blocked = 1'b0;
`ifdef IQ_AGE_SELECT_EN
                for (int k = 0; k < DEPTH; k++)
                    if (cand[k] && age_q[k][e]) blocked = 1'b1;
`endif
                if (fu_ready[j] && cand[e] && !blocked && !sel_ok[j]) begin
                    sel_ok[j]  = 1'b1;
                    sel_idx[j] = IDXW'(e);
                end
            end
            if (sel_ok[j]) issued[sel_idx[j]] = 1'b1;
        end

        valid_d = valid_q & ~issued & ~squash;
        for (int i = 0; i < ENW; i++)
            if (alloc_ok[i]) valid_d[alloc_idx[i]] = 1'b1;
        occ_d = '0;
        for (int e = 0; e < DEPTH; e++) occ_d = occ_d + CNTW'(valid_d[e]);

`ifdef IQ_AGE_SELECT_EN
        age_d = age_q;
        for (int i = 0; i < ENW; i++)
            if (alloc_ok[i]) begin
                for (int k = 0; k < DEPTH; k++) age_d[alloc_idx[i]][k] = 1'b0;
                for (int k = 0; k < DEPTH; k++) age_d[k][alloc_idx[i]] = valid_q[k];
                for (int p = 0; p < i; p++)
                    if (alloc_ok[p]) age_d[alloc_idx[p]][alloc_idx[i]] = 1'b1;
            end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            occ_q       <= '0;
            iss_valid_q <= '0;
`ifdef IQ_AGE_SELECT_EN
            age_q       <= '0;
`endif
        end else begin
            valid_q     <= valid_d;
            occ_q       <= occ_d;
            iss_valid_q <= sel_ok;
`ifdef IQ_AGE_SELECT_EN
            age_q       <= age_d;
`endif
        end
    end

    // Entry contents and issue data need no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        busy_q <= busy_now;
        for (int i = 0; i < ENW; i++)
            if (alloc_ok[i]) begin
                opid_q[alloc_idx[i]]    <= enq_opid[i*OPW +: OPW];
                fu_q[alloc_idx[i]]      <= enq_fu[i*NFU +: NFU];
                payload_q[alloc_idx[i]] <= enq_payload[i*PW +: PW];
                for (int s = 0; s < 2; s++) begin
                    src_q[alloc_idx[i]][s]  <= enq_src[(i*2+s)*TAGW +: TAGW];
                    busy_q[alloc_idx[i]][s] <= enq_busy[i*2+s] &
                        ~wk_hit(enq_src[(i*2+s)*TAGW +: TAGW], wk_valid, wk_tag);
                end
            end
        for (int j = 0; j < NFU; j++)
            if (sel_ok[j]) begin
                iss_opid_q[j*OPW +: OPW]  <= opid_q[sel_idx[j]];
                iss_payload_q[j*PW +: PW] <= payload_q[sel_idx[j]];
            end
    end

    assign iss_valid   = iss_valid_q;
    assign iss_opid    = iss_opid_q;
    assign iss_payload = iss_payload_q;
    assign occ_cnt     = occ_q;
endmodule
